// File: rtl/grid_pixel_streamer.sv
// grid_pixel_streamer
// Serialises a ROWS x COLS grid of 2-bit cell codes into a stream of 24-bit
// pixel words for an addressable LED strip, one frame per step_game pulse.
// Odd rows may be wired right-to-left (serpentine). After every frame the
// streamer stays idle for LATCH_CYCLES cycles so the strip can latch.
// One extra request may be queued while a frame is in flight. Any further
// request is dropped and counted.
module grid_pixel_streamer #(
   parameter int          ROWS         = 8,
   parameter int          COLS         = 8,
   parameter int          SERPENTINE   = 1,
   parameter int          LATCH_CYCLES = 2500,
   parameter logic [23:0] COLOR_0      = 24'h000000,
   parameter logic [23:0] COLOR_1      = 24'h00FF00,
   parameter logic [23:0] COLOR_2      = 24'hFF0000,
   parameter logic [23:0] COLOR_3      = 24'h0000FF
) (
   input  logic                            clk,
   input  logic                            SW,
   input  logic                            step_game,
   input  logic [2*ROWS*COLS-1:0]          grid,
   output logic                            px_valid,
   output logic [23:0]                     px_color,
   output logic [$clog2(ROWS*COLS)-1:0]    px_index,
   input  logic                            px_ready,
   output logic                            busy,
   output logic                            frame_done,
   output logic [7:0]                      overrun_cnt
);

   localparam int NPIX = ROWS * COLS;
   localparam int IW   = $clog2(NPIX);
   localparam int LW   = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NPIX - 1);
   localparam logic [LW-1:0] LAST_LAT = LW'(LATCH_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_LATCH  = 2'd2
   } state_t;

   state_t              state_r, state_s;
   logic [2*NPIX-1:0]   shadow_r, shadow_s;
   logic [IW-1:0]       idx_r, idx_s;
   logic [LW-1:0]       lcnt_r, lcnt_s;
   logic                pend_r, pend_s;
   logic [7:0]          ovr_r, ovr_s;
   logic                ovr_inc_s;
   logic                xfer_s;
   logic                last_lat_s;

   logic                px_valid_r;
   logic [23:0]         px_color_r;
   logic [IW-1:0]       px_index_r;
   logic                busy_r;
   logic                frame_done_r;

   // Map a 2-bit cell code to its display colour.
   function automatic logic [23:0] code_color(input logic [1:0] code);
      logic [23:0] col;
      case (code)
         2'b00:   col = COLOR_0;
         2'b01:   col = COLOR_1;
         2'b10:   col = COLOR_2;
         2'b11:   col = COLOR_3;
         default: col = COLOR_0;
      endcase
      return col;
   endfunction

   // Colour of strip position k: row-major, odd rows mirrored when serpentine.
   function automatic logic [23:0] pixel_color(input logic [2*NPIX-1:0] frame,
                                               input logic [IW-1:0]     k);
      int r;
      int p;
      int c;
      r = int'(k) / COLS;
      p = int'(k) % COLS;
      if ((SERPENTINE != 0) && ((r % 2) == 1)) begin
         c = COLS - 1 - p;
      end else begin
         c = p;
      end
      return code_color(frame[2*(r*COLS + c) +: 2]);
   endfunction

   assign xfer_s     = px_valid_r & px_ready;
   assign last_lat_s = (lcnt_r == LAST_LAT);

   // Next-state logic: frame sequencing, request queuing and overrun counting.
   always_comb begin
      state_s   = state_r;
      shadow_s  = shadow_r;
      idx_s     = idx_r;
      lcnt_s    = lcnt_r;
      pend_s    = pend_r;
      ovr_inc_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (step_game) begin
               state_s  = ST_STREAM;
               shadow_s = grid;
               idx_s    = {IW{1'b0}};
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (step_game) begin
               if (pend_r) begin
                  ovr_inc_s = 1'b1;
               end else begin
                  pend_s = 1'b1;
               end
            end else begin
               pend_s = pend_r;
            end
            if (xfer_s) begin
               if (idx_r == LAST_IDX) begin
                  state_s = ST_LATCH;
                  lcnt_s  = {LW{1'b0}};
               end else begin
                  idx_s   = idx_r + {{(IW-1){1'b0}}, 1'b1};
               end
            end else begin
               idx_s = idx_r;
            end
         end
         ST_LATCH: begin
            if (last_lat_s) begin
               // A request arriving on the final cycle joins the queue and is
               // served by the same transition; a second one is dropped.
               if (pend_r || step_game) begin
                  ovr_inc_s = pend_r & step_game;
                  pend_s    = 1'b0;
                  state_s   = ST_STREAM;
                  shadow_s  = grid;
                  idx_s     = {IW{1'b0}};
               end else begin
                  state_s   = ST_IDLE;
               end
            end else begin
               lcnt_s = lcnt_r + {{(LW-1){1'b0}}, 1'b1};
               if (step_game) begin
                  if (pend_r) begin
                     ovr_inc_s = 1'b1;
                  end else begin
                     pend_s = 1'b1;
                  end
               end else begin
                  pend_s = pend_r;
               end
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      if (ovr_inc_s && (ovr_r != 8'hFF)) begin
         ovr_s = ovr_r + 8'd1;
      end else begin
         ovr_s = ovr_r;
      end
   end

   // State, shadow frame and registered pixel outputs.
   always_ff @(posedge clk or negedge SW) begin
      if (!SW) begin
         state_r      <= ST_IDLE;
         shadow_r     <= {(2*NPIX){1'b0}};
         idx_r        <= {IW{1'b0}};
         lcnt_r       <= {LW{1'b0}};
         pend_r       <= 1'b0;
         ovr_r        <= 8'd0;
         px_valid_r   <= 1'b0;
         px_color_r   <= 24'd0;
         px_index_r   <= {IW{1'b0}};
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         shadow_r     <= shadow_s;
         idx_r        <= idx_s;
         lcnt_r       <= lcnt_s;
         pend_r       <= pend_s;
         ovr_r        <= ovr_s;
         px_valid_r   <= (state_s == ST_STREAM);
         px_color_r   <= (state_s == ST_STREAM) ? pixel_color(shadow_s, idx_s) : 24'd0;
         px_index_r   <= (state_s == ST_STREAM) ? idx_s : {IW{1'b0}};
         busy_r       <= (state_s != ST_IDLE);
         frame_done_r <= (state_s == ST_LATCH) && (lcnt_s == LAST_LAT);
      end
   end

   assign px_valid    = px_valid_r;
   assign px_color    = px_color_r;
   assign px_index    = px_index_r;
   assign busy        = busy_r;
   assign frame_done  = frame_done_r;
   assign overrun_cnt = ovr_r;

endmodule

// File: doc/grid_pixel_streamer.md
GRID_PIXEL_STREAMER -- requirements
Module: grid_pixel_streamer

Interface
REQ-001 Parameter ROWS, default 8: matrix rows.
REQ-002 Parameter COLS, default 8: matrix columns.
REQ-003 Parameter SERPENTINE, default 1: 1 = odd rows wired right-to-left.
REQ-004 Parameter LATCH_CYCLES, default 2500: idle gap after each frame (WS2812 reset time).
REQ-005 Parameters COLOR_0..COLOR_3, defaults 24'h000000, 24'h00FF00, 24'hFF0000, 24'h0000FF: 24-bit colour for cell codes 00/01/10/11.
REQ-006 clk  input  1  system clock, all logic on rising edge.
REQ-007 SW  input  1  reset, asynchronous, active-low.
REQ-008 step_game  input  1  single-cycle pulse: new generation available.
REQ-009 grid  input  2*ROWS*COLS  cell states; cell (r,c) at bits [2*(r*COLS+c) +: 2].
REQ-010 px_valid  output  1  pixel word valid.
REQ-011 px_color  output  24  colour of current pixel.
REQ-012 px_index  output  $clog2(ROWS*COLS)  strip position of current pixel.
REQ-013 px_ready  input  1  downstream LED driver accepts pixel.
REQ-014 busy  output  1  high in STREAM or LATCH.
REQ-015 frame_done  output  1  single-cycle pulse at end of LATCH.
REQ-016 overrun_cnt  output  8  count of dropped step_game pulses, saturating at 255.

Function
REQ-017 States SHALL be IDLE, STREAM, LATCH.
REQ-018 IDLE + step_game: copy grid into shadow register, index=0, enter STREAM; px_valid SHALL be high the next cycle (latency 1).
REQ-019 STREAM SHALL present pixel k from the shadow register: r=k/COLS, p=k%COLS, c = (SERPENTINE && r odd) ? COLS-1-p : p; px_color = COLOR_[cell(r,c)]; px_index = k.
REQ-020 Transfer SHALL occur only on a cycle with px_valid && px_ready; index advances by one per transfer.
REQ-021 While px_valid && !px_ready, px_color and px_index SHALL hold stable.
REQ-022 Transfer of index ROWS*COLS-1: px_valid low next cycle, enter LATCH.
REQ-023 LATCH SHALL last exactly LATCH_CYCLES cycles with px_valid low; frame_done SHALL pulse on its final cycle; then go to IDLE, or directly to STREAM if pending is set.
REQ-024 step_game while busy and pending clear SHALL set pending; grid is sampled into the shadow register when the pending frame starts, not when the pulse arrived.
REQ-025 step_game while busy and pending already set SHALL be dropped and increment overrun_cnt (saturate at 255).
REQ-026 Pending start from LATCH SHALL clear pending and behave as REQ-018 in the same transition cycle.
REQ-027 step_game coinciding with the final LATCH cycle SHALL set pending (no drop unless pending already set).
REQ-028 Shadow register SHALL be unaffected by grid changes during STREAM/LATCH.
REQ-029 px_ready while px_valid low SHALL have no effect.

Reset
REQ-030 SW low SHALL immediately force IDLE, px_valid=0, px_index=0, px_color=0, busy=0, frame_done=0, pending=0, overrun_cnt=0, shadow=0, latch counter=0.
REQ-031 Reset asserted mid-STREAM SHALL abort the frame; no frame_done; after release, wait for a new step_game.

Verification
REQ-032 All-zero grid except cell (0,0)=01, px_ready tied 1, step_game pulse -> px_valid next cycle; index 0 colour 24'h00FF00; indices 1..63 colour 0; 64 consecutive transfers; frame_done exactly LATCH_CYCLES cycles after last transfer.
REQ-033 Cell (1,0)=10, SERPENTINE=1 -> red appears at px_index 15; with SERPENTINE=0 -> at px_index 8.
REQ-034 px_ready random 50% duty -> px_color/px_index stable across every stall; exactly 64 transfers, indices 0..63 in order.
REQ-035 Three step_game pulses during one frame -> pending set by first, overrun_cnt=2; second frame starts on final LATCH cycle transition with grid value at that moment; third frame never starts.
REQ-036 Change grid mid-STREAM -> remaining pixels reflect grid captured at start.
REQ-037 SW low at pixel 30 -> all outputs zero asynchronously, no frame_done; next step_game after release restarts at px_index 0.
